// File: rtl/i2c_wb_target_if.sv
// ---------------------------------------------------------------------------
// i2c_wb_target_if
// I2C target (slave) responder attached to NUM_BUSSES SCL/SDA pairs. It serves
// the one bus selected in CTRL.BUS_SEL and answers address TARGET_ADDR.
// Host software reaches it through a 4-register Wishbone slave port.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-low reset
//   scl_i/sda_i  SCL/SDA of every attached bus
//   sda_o        open-drain SDA per bus (0 = pull low, 1 = released)
//   cyc_i/stb_i/we_i/adr_i/dat_i   Wishbone request
//   dat_o/ack_o  Wishbone read data and single-cycle acknowledge
//   irq_o        level interrupt: IE & (RXV | STOP | NACK)
//
// Registers: 0 CTRL {EN,IE,0,0,BUS_SEL[3:0]}
//            1 STAT {RW,0,0,NACK,STOP,OVR,RXV,BUSY}  (OVR/STOP/NACK are W1C)
//            2 RXDATA (read clears RXV)   3 TXDATA
// ---------------------------------------------------------------------------
module i2c_wb_target_if #(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_BUSSES     = 16,
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_BUSSES-1:0]    scl_i,
    input  logic [NUM_BUSSES-1:0]    sda_i,
    output logic [NUM_BUSSES-1:0]    sda_o,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    output logic                     ack_o,
    output logic                     irq_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
    } state_t;

    state_t                    state_r;
    logic                      en_r, ie_r;
    logic [3:0]                bus_sel_r, sel_prev_r;
    logic                      busy_r, rxv_r, ovr_r, stop_r, nack_r, rw_r;
    logic [I2C_DATA_WIDTH-1:0] rxdata_r, txdata_r, shift_r;
    logic [3:0]                cnt_r;
    logic                      ack_on_r;   // second half of an ACK slot is in progress
    logic                      drive_r;    // 1 = pull SDA of the selected bus low
    logic                      scl_meta_r, scl_sync_r, scl_prev_r;
    logic                      sda_meta_r, sda_sync_r, sda_prev_r;

    logic                      wb_req_s, wb_wr_s, wb_rd_s;
    logic                      scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [I2C_DATA_WIDTH-1:0] byte_s;
    logic                      addr_match_s;

    assign wb_req_s     = cyc_i & stb_i & ~ack_o;
    assign wb_wr_s      = wb_req_s & we_i;
    assign wb_rd_s      = wb_req_s & ~we_i;
    assign scl_rise_s   = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s   = ~scl_sync_r & scl_prev_r;
    // START/STOP require SCL high on both samples around the SDA transition
    assign start_s      = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s       = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    // byte as it stands once the bit on the current rising edge is shifted in
    assign byte_s       = {shift_r[I2C_DATA_WIDTH-2:0], sda_sync_r};
    assign addr_match_s = (byte_s[I2C_DATA_WIDTH-1:1] == TARGET_ADDR);

    // Two-flop synchronizer plus one history flop for the selected bus lines
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scl_meta_r <= 1'b0; scl_sync_r <= 1'b0; scl_prev_r <= 1'b0;
            sda_meta_r <= 1'b0; sda_sync_r <= 1'b0; sda_prev_r <= 1'b0;
        end else begin
            scl_meta_r <= scl_i[bus_sel_r];
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda_i[bus_sel_r];
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // Wishbone register port and I2C target state machine
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= S_IDLE;
            en_r       <= 1'b0;  ie_r   <= 1'b0;
            bus_sel_r  <= 4'd0;  sel_prev_r <= 4'd0;
            busy_r     <= 1'b0;  rxv_r  <= 1'b0;  ovr_r  <= 1'b0;
            stop_r     <= 1'b0;  nack_r <= 1'b0;  rw_r   <= 1'b0;
            rxdata_r   <= 8'h00; txdata_r <= 8'h00; shift_r <= 8'h00;
            cnt_r      <= 4'd0;  ack_on_r <= 1'b0; drive_r <= 1'b0;
            dat_o      <= 8'h00; ack_o    <= 1'b0;
        end else begin
            ack_o      <= wb_req_s;
            sel_prev_r <= bus_sel_r;

            if (wb_wr_s) begin
                case (adr_i)
                    2'd0: begin
                        en_r      <= dat_i[7];
                        ie_r      <= dat_i[6];
                        bus_sel_r <= dat_i[3:0];
                    end
                    2'd1: begin
                        if (dat_i[2]) ovr_r  <= 1'b0;
                        if (dat_i[3]) stop_r <= 1'b0;
                        if (dat_i[4]) nack_r <= 1'b0;
                    end
                    2'd3:    txdata_r <= dat_i;
                    default: ;
                endcase
            end

            if (wb_rd_s) begin
                case (adr_i)
                    2'd0:    dat_o <= {en_r, ie_r, 2'b00, bus_sel_r};
                    2'd1:    dat_o <= {rw_r, 2'b00, nack_r, stop_r, ovr_r, rxv_r, busy_r};
                    2'd2: begin
                        dat_o <= rxdata_r;
                        rxv_r <= 1'b0;
                    end
                    2'd3:    dat_o <= txdata_r;
                    default: dat_o <= 8'h00;
                endcase
            end

            // Flag updates below come after the Wishbone side so a hardware
            // set wins over a same-cycle W1C or RXDATA read.
            if (!en_r || (bus_sel_r != sel_prev_r)) begin
                state_r  <= S_IDLE;
                busy_r   <= 1'b0;
                drive_r  <= 1'b0;
                ack_on_r <= 1'b0;
                cnt_r    <= 4'd0;
            end else if (stop_s) begin
                state_r  <= S_IDLE;
                busy_r   <= 1'b0;
                drive_r  <= 1'b0;
                ack_on_r <= 1'b0;
                stop_r   <= 1'b1;
            end else if (start_s) begin
                // START from IDLE and repeated START both restart addressing
                state_r  <= S_ADDR;
                busy_r   <= 1'b1;
                drive_r  <= 1'b0;
                ack_on_r <= 1'b0;
                cnt_r    <= 4'd0;
            end else begin
                case (state_r)
                    S_IDLE: drive_r <= 1'b0;
                    S_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r <= byte_s;
                            if (cnt_r == 4'd7) begin
                                cnt_r   <= 4'd0;
                                rw_r    <= byte_s[0];
                                state_r <= addr_match_s ? S_ADDR_ACK : S_WAIT;
                            end else begin
                                cnt_r <= cnt_r + 4'd1;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                ack_on_r <= 1'b1;
                                drive_r  <= 1'b1;
                            end else begin
                                ack_on_r <= 1'b0;
                                cnt_r    <= 4'd0;
                                if (rw_r) begin
                                    // present the MSB on the same falling edge that ends the ACK
                                    state_r <= S_RD_DATA;
                                    shift_r <= {txdata_r[6:0], 1'b0};
                                    drive_r <= ~txdata_r[7];
                                end else begin
                                    state_r <= S_WR_DATA;
                                    drive_r <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (scl_rise_s) begin
                            shift_r <= byte_s;
                            if (cnt_r == 4'd7) begin
                                cnt_r    <= 4'd0;
                                rxdata_r <= byte_s;
                                rxv_r    <= 1'b1;
                                if (rxv_r) ovr_r <= 1'b1;
                                state_r  <= S_WR_ACK;
                            end else begin
                                cnt_r <= cnt_r + 4'd1;
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_on_r) begin
                                ack_on_r <= 1'b1;
                                drive_r  <= 1'b1;
                            end else begin
                                ack_on_r <= 1'b0;
                                drive_r  <= 1'b0;
                                state_r  <= S_WR_DATA;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_fall_s) begin
                            if (cnt_r == 4'd8) begin
                                drive_r <= 1'b0;
                                state_r <= S_RD_ACK;
                            end else begin
                                drive_r <= ~shift_r[7];
                                shift_r <= {shift_r[6:0], 1'b0};
                            end
                        end else if (scl_rise_s) begin
                            cnt_r <= cnt_r + 4'd1;
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise_s) begin
                            if (!sda_sync_r) begin
                                // first bit goes out on the coming falling edge
                                shift_r <= txdata_r;
                                cnt_r   <= 4'd0;
                                state_r <= S_RD_DATA;
                            end else begin
                                nack_r  <= 1'b1;
                                state_r <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: drive_r <= 1'b0;
                    default: begin
                        state_r <= S_IDLE;
                        drive_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Open-drain output routing: only the selected bus can ever be pulled low
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sda_o <= {NUM_BUSSES{1'b1}};
        end else begin
            sda_o <= {NUM_BUSSES{1'b1}};
            if (en_r && drive_r) sda_o[bus_sel_r] <= 1'b0;
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= ie_r & (rxv_r | stop_r | nack_r);
        end
    end

endmodule

// File: tb/tb_i2c_wb_target_if.sv
// ---------------------------------------------------------------------------
// tb_i2c_wb_target_if
// Self-checking bench: a bit-banged I2C master drives the bus lines, a
// Wishbone host task reads/writes registers, and a transaction-level model
// predicts ACKs, read bytes, status flags, RXDATA and irq_o.
// ---------------------------------------------------------------------------
module tb_i2c_wb_target_if;

    localparam int HT = 10;   // clocks per SCL half period

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] scl_m, sda_m, sda_line;
    logic [15:0] sda_o;
    logic        cyc, stb, we;
    logic [1:0]  adr;
    logic [7:0]  dat_wr, dat_rd;
    logic        ack_o, irq_o;

    always #5 clk = ~clk;

    // wired-AND of master and target on every bus
    assign sda_line = sda_m & sda_o;

    i2c_wb_target_if dut (
        .clk_i(clk), .rst_i(rst_i),
        .scl_i(scl_m), .sda_i(sda_line), .sda_o(sda_o),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat_wr),
        .dat_o(dat_rd), .ack_o(ack_o), .irq_o(irq_o)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic       m_en = 1'b0, m_ie = 1'b0;
    int         cur_sel = 0;
    logic       m_rxv = 1'b0, m_ovr = 1'b0, m_stop = 1'b0, m_nack = 1'b0, m_rw = 1'b0;
    logic [7:0] m_rxdata = 8'h00, m_tx = 8'h00;
    logic [7:0] wbuf [4];

    // bus monitors
    int low_cnt   = 0;
    int route_err = 0;

    always @(negedge clk) begin
        if (sda_o != 16'hFFFF) low_cnt <= low_cnt + 1;
        for (int b = 0; b < 16; b++)
            if (b != cur_sel && sda_o[b] == 1'b0) route_err <= route_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                           output logic [7:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_wr = d;
        @(posedge clk); #1;
        chk("wb_ack", 32'(ack_o), 32'd1);
        rd  = dat_rd;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("wb_ack_one_cycle", 32'(ack_o), 32'd0);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [7:0] d);
        wb_xfer(1'b0, a, 8'h00, d);
    endtask

    function automatic logic [7:0] m_stat();
        return {m_rw, 2'b00, m_nack, m_stop, m_ovr, m_rxv, 1'b0};
    endfunction

    task automatic check_regs(input string tag);
        logic [7:0] st;
        wb_rd(2'd1, st);
        chk({tag, "_stat"}, 32'(st), 32'(m_stat()));
        chk({tag, "_irq"}, 32'(irq_o), 32'(m_ie & (m_rxv | m_stop | m_nack)));
    endtask

    task automatic read_rx(input string tag);
        logic [7:0] d;
        wb_rd(2'd2, d);
        chk({tag, "_rxdata"}, 32'(d), 32'(m_rxdata));
        m_rxv = 1'b0;
    endtask

    task automatic clear_flags();
        wb_wr(2'd1, 8'h1C);
        m_ovr = 1'b0; m_stop = 1'b0; m_nack = 1'b0;
    endtask

    // ---- I2C master primitives (SCL is low between bits) ----
    task automatic i2c_start(input int b);
        sda_m[b] = 1'b0; wclk(HT);
        scl_m[b] = 1'b0; wclk(2);
    endtask

    task automatic i2c_bit(input int b, input logic v, output logic s);
        sda_m[b] = v;    wclk(HT);
        scl_m[b] = 1'b1; wclk(HT);
        s = sda_line[b];
        scl_m[b] = 1'b0; wclk(2);
    endtask

    task automatic i2c_stop(input int b);
        sda_m[b] = 1'b0; wclk(HT);
        scl_m[b] = 1'b1; wclk(HT);
        sda_m[b] = 1'b1; wclk(HT);
    endtask

    task automatic i2c_wbyte(input int b, input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b, d[i], s);
        i2c_bit(b, 1'b1, ack);
    endtask

    task automatic i2c_rbyte(input int b, input logic nak, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(b, 1'b1, s);
            d[i] = s;
        end
        i2c_bit(b, nak, s);
    endtask

    // One complete transaction on bus b, predicted at transaction level:
    // the target answers only on the selected bus while enabled, only for
    // its own address; written bytes land in RXDATA (overrun if unread),
    // read bytes all equal TXDATA, and the closing NACK sets the NACK flag.
    task automatic txn(input string tag, input int b, input logic [6:0] a,
                       input logic rw, input int n);
        logic       ack, sel, hit;
        logic [7:0] d, st;
        sel = (b == cur_sel) && m_en;
        hit = sel && (a == 7'h22);
        i2c_start(b);
        i2c_wbyte(b, {a, rw}, ack);
        chk({tag, "_addr_ack"}, 32'(ack), hit ? 32'd0 : 32'd1);
        if (sel) m_rw = rw;
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                if (!rw) begin
                    i2c_wbyte(b, wbuf[i], ack);
                    chk({tag, "_data_ack"}, 32'(ack), 32'd0);
                    if (m_rxv) m_ovr = 1'b1;
                    m_rxv    = 1'b1;
                    m_rxdata = wbuf[i];
                end else begin
                    i2c_rbyte(b, (i == n - 1), d);
                    chk({tag, "_rd_byte"}, 32'(d), 32'(m_tx));
                end
            end
            if (rw) m_nack = 1'b1;
        end
        wb_rd(2'd1, st);
        chk({tag, "_busy_mid"}, 32'(st[0]), 32'(sel));
        i2c_stop(b);
        if (sel) m_stop = 1'b1;
        wclk(4);
        check_regs(tag);
    endtask

    initial begin
        logic [7:0] d;
        int         lc, b, n;
        logic [6:0] a;
        logic       rw;

        rst_i = 1'b0;
        scl_m = 16'hFFFF; sda_m = 16'hFFFF;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_wr = 8'h00;
        wclk(2);
        chk("rst_ack",  32'(ack_o), 32'd0);
        chk("rst_irq",  32'(irq_o), 32'd0);
        chk("rst_sda",  32'(sda_o), 32'hFFFF);
        chk("rst_dat",  32'(dat_rd), 32'd0);
        rst_i = 1'b1;
        wclk(2);
        wb_rd(2'd1, d);
        chk("rst_stat", 32'(d), 32'd0);

        // register access; unused CTRL bits read back as 0
        wb_wr(2'd0, 8'hF5);
        m_en = 1'b1; m_ie = 1'b1; cur_sel = 5;
        wb_rd(2'd0, d);
        chk("ctrl_rb", 32'(d), 32'hC5);
        wb_wr(2'd3, 8'h96);
        wb_rd(2'd3, d);
        chk("tx_rb", 32'(d), 32'h96);
        wclk(8);

        // I2C write of 0xA5
        wbuf[0] = 8'hA5;
        txn("wr", 5, 7'h22, 1'b0, 1);
        read_rx("wr");
        clear_flags();
        check_regs("wr_clr");

        // I2C read of two bytes of 0x3C
        wb_wr(2'd3, 8'h3C); m_tx = 8'h3C;
        txn("rd", 5, 7'h22, 1'b1, 2);
        clear_flags();

        // address mismatch (0x50 on the wire): SDA never pulled low
        lc = low_cnt;
        wbuf[0] = 8'h11;
        txn("mis", 5, 7'h28, 1'b0, 1);
        chk("mis_no_drive", 32'(low_cnt - lc), 32'd0);
        clear_flags();

        // overrun: two unread bytes
        wbuf[0] = 8'hA1; wbuf[1] = 8'h5E;
        txn("ovr", 5, 7'h22, 1'b0, 2);
        read_rx("ovr");
        clear_flags();

        // unselected bus 3 is ignored
        lc = low_cnt;
        txn("bus3", 3, 7'h22, 1'b0, 1);
        chk("bus3_no_drive", 32'(low_cnt - lc), 32'd0);

        // disabled target ignores its own bus
        wb_wr(2'd0, 8'h45); m_en = 1'b0;
        txn("dis", 5, 7'h22, 1'b0, 1);
        wb_wr(2'd0, 8'hC5); m_en = 1'b1;
        wclk(8);

        // randomized transactions
        for (int it = 0; it < 14; it++) begin
            b  = ($urandom_range(0, 4) == 0) ? 3 : 5;
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            if ($urandom_range(0, 2) == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h22) a = 7'h23;
            end else begin
                a = 7'h22;
            end
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
            if (rw) begin
                m_tx = 8'($urandom_range(0, 255));
                wb_wr(2'd3, m_tx);
            end
            txn("rnd", b, a, rw, n);
            if ($urandom_range(0, 1) == 1) read_rx("rnd");
            if ($urandom_range(0, 1) == 1) begin
                clear_flags();
                check_regs("rnd_clr");
            end
        end

        chk("routing", 32'(route_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
